pipe_adder: RTL and testbench
=============================

# pipe_adder

Parametrised, pipelined ripple-carry adder with carry-in, carry-out and signed-overflow flag. The WIDTH-bit operation is split into STAGES equal chunks, one chunk per pipeline stage, so long carry chains are broken into registered segments. A valid/ready handshake on both sides lets the block sit between arithmetic producers and consumers; it replaces the fixed combinational 8-bit byte adder in datapaths that need wider words or higher clock rates.

## Interface
- WIDTH, 8, operand/sum width in bits; must be a multiple of STAGES
- STAGES, 2, pipeline depth; chunk width CW = WIDTH/STAGES; STAGES >= 1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- sub  in  1  subtract mode (present only with PIPE_ADDER_SUB_EN)
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry-out of bit WIDTH-1
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB

## Operation
- Stage k (0..STAGES-1) adds chunk k of a and b plus carry from stage k-1 (stage 0 uses cin), registering CW sum bits and carry.
- Upper operand chunks travel through skew registers; completed lower sum chunks through deskew registers, so a whole result leaves the last stage aligned.
- Each stage holds a valid bit. Global advance: en = out_ready | ~out_valid. When en=1 every stage shifts one place; stage 0 loads a,b,cin if in_valid, else loads a bubble (valid 0).
- in_ready = en. Transfer in occurs when in_valid & in_ready; transfer out when out_valid & out_ready.
- Bubbles are not collapsed; a stalled pipeline holds all stages, including empty ones.
- Result arithmetic: {cout,sum} = a + b + cin, width WIDTH+1. ovf = a[MSB]==b[MSB] && sum[MSB]!=a[MSB].
- STAGES=1: single registered adder, latency 1.

## Timing
- Latency: exactly STAGES cycles from accepted input to out_valid, with out_ready held high.
- Throughput: one result per cycle when out_ready=1.
- Reset: all valid bits 0; out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 in the first cycle after reset since out_valid=0. Reset mid-operation discards all in-flight data, with no partial results emitted.
- out_valid held with sum/cout/ovf stable while out_ready=0; in_ready=0 in the same cycles.
- Simultaneous in/out transfer at full pipeline: allowed, no loss, ordering preserved.
- Inputs sampled only on transfer cycles; changes on a, b or cin while in_ready=0 are ignored.

## Configuration
- PIPE_ADDER_SUB_EN defined: sub port exists. When sub=1, stage 0 uses ~b and the carry-in is forced to 1. The cin input is ignored in that mode, so the result is a - b, with cout=1 meaning no borrow and ovf giving signed subtraction overflow. sub travels with its operands.
- Undefined: no sub port; add only.

## Structure
- Shared package pipe_adder_pkg: function computing CW from WIDTH/STAGES, and an elaboration-time check that WIDTH % STAGES == 0.
- One sub-module, adder_chunk: combinational CW-bit adder (a, b, cin -> s, co, plus carry into its MSB for the ovf calculation). It is instantiated once per stage; the top holds all registers and handshake logic.

## Test plan
- Defaults, out_ready=1, a=0x00, b=0x01, cin=0 -> after 2 cycles out_valid=1, sum=0x01, cout=0, ovf=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- Stream a=0..127 back-to-back with b=1, then a=0x80 with b=0x81..0xFF -> one result per cycle, each sum = a+b mod 256, in order.
- Stall: fill pipeline, out_ready=0 for 5 cycles -> in_ready=0, outputs frozen; release -> no loss or duplication.
- Assert rst with 2 items in flight -> next cycle out_valid=0, sum=0, and none of the discarded items ever appears.
- WIDTH=32, STAGES=4, a=0xFFFFFFFF, b=0, cin=1 -> latency 4, sum=0, cout=1, with the carry rippling across all stages. With PIPE_ADDER_SUB_EN, sub=1, a=5, b=7 at WIDTH=8 -> sum=0xFE, cout=0.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared helpers for pipe_adder: chunk width derivation and configuration sanity check.
package pipe_adder_pkg;

  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  function automatic bit config_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit ripple adder slice; also exposes the carry into its MSB so the
// last slice can form the signed-overflow flag.
module adder_chunk
  import pipe_adder_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  input  logic          i_ci,
  output logic [CW-1:0] o_s,
  output logic          o_co,
  output logic          o_cm
);

  logic [CW:0] w_carry;

  always_comb begin
    w_carry    = '0;
    o_s        = '0;
    w_carry[0] = i_ci;
    for (int i = 0; i < CW; i++) begin
      o_s[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
      w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_co = w_carry[CW];
  assign o_cm = w_carry[CW-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder, one CW-bit chunk per stage, valid/ready on both sides.
// Optional subtract mode (sub port, a - b) is enabled by defining PIPE_ADDER_SUB_EN.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = chunk_width(WIDTH, STAGES);

  if (!config_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("pipe_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic             w_en;
  logic [WIDTH-1:0] w_b0;
  logic             w_cin0;

  // Whole pipeline advances together; bubbles are kept, never collapsed.
  assign w_en     = out_ready | ~out_valid;
  assign in_ready = w_en;

`ifdef PIPE_ADDER_SUB_EN
  assign w_b0   = sub ? ~b : b;
  assign w_cin0 = sub | cin;
`else
  assign w_b0   = b;
  assign w_cin0 = cin;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned RemW = (STAGES - k) * CW;

    logic [RemW-1:0]     w_a_rem;
    logic [RemW-1:0]     w_b_rem;
    logic                w_ci;
    logic                w_vin;
    logic [CW-1:0]       w_s;
    logic                w_co;
    logic                w_cm;
    logic                r_v;
    logic                r_c;
    logic [(k+1)*CW-1:0] r_s;

    // w_a_rem/w_b_rem hold operand chunks k and up; chunk k is consumed here.
    if (k == 0) begin : g_src
      assign w_a_rem = a;
      assign w_b_rem = w_b0;
      assign w_ci    = w_cin0;
      assign w_vin   = in_valid;
    end else begin : g_src
      assign w_a_rem = g_stage[k-1].g_skew.r_a;
      assign w_b_rem = g_stage[k-1].g_skew.r_b;
      assign w_ci    = g_stage[k-1].r_c;
      assign w_vin   = g_stage[k-1].r_v;
    end

    adder_chunk #(
      .CW(CW)
    ) u_chunk (
      .i_a (w_a_rem[CW-1:0]),
      .i_b (w_b_rem[CW-1:0]),
      .i_ci(w_ci),
      .o_s (w_s),
      .o_co(w_co),
      .o_cm(w_cm)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
      end else if (w_en) begin
        r_v <= w_vin;
        r_c <= w_co;
      end
    end

    if (k == 0) begin : g_sum
      always_ff @(posedge clk) begin
        if (rst) begin
          r_s <= '0;
        end else if (w_en) begin
          r_s <= w_s;
        end
      end
    end else begin : g_sum
      always_ff @(posedge clk) begin
        if (rst) begin
          r_s <= '0;
        end else if (w_en) begin
          r_s <= {w_s, g_stage[k-1].r_s};
        end
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [RemW-CW-1:0] r_a;
      logic [RemW-CW-1:0] r_b;
      logic               w_unused_cm;

      assign w_unused_cm = w_cm;

      always_ff @(posedge clk) begin
        if (w_en) begin
          r_a <= w_a_rem[RemW-1:CW];
          r_b <= w_b_rem[RemW-1:CW];
        end
      end
    end else begin : g_last
      logic r_ovf;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_en) begin
          r_ovf <= w_co ^ w_cm;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign cout      = g_stage[STAGES-1].r_c;
  assign sum       = g_stage[STAGES-1].r_s;
  assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: 8-bit/2-stage instance with scoreboard plus a 32-bit/4-stage instance.
module tb_pipe_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp8_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [7:0]  a, b, sum;
  logic        in_valid32, in_ready32, cin32, sub32, out_valid32, out_ready32, cout32, ovf32;
  logic [31:0] a32, b32, sum32;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pops   = 0;
  exp8_t       exp_q[$];
  exp8_t       e_mon;
  logic        hold_pend = 1'b0;
  logic [10:0] hold_val;

  always #5 clk = ~clk;

  pipe_adder #(
    .WIDTH (8),
    .STAGES(2)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef PIPE_ADDER_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  pipe_adder #(
    .WIDTH (32),
    .STAGES(4)
  ) u_dut32 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid32),
    .in_ready (in_ready32),
    .a        (a32),
    .b        (b32),
    .cin      (cin32),
`ifdef PIPE_ADDER_SUB_EN
    .sub      (sub32),
`endif
    .out_valid(out_valid32),
    .out_ready(out_ready32),
    .sum      (sum32),
    .cout     (cout32),
    .ovf      (ovf32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; overflow means the signed result is out of range.
  function automatic exp8_t model8(input logic [7:0] ia, input logic [7:0] ib,
                                   input logic ic, input logic is);
    exp8_t e;
    int ua = ia;
    int ub = ib;
    int sa = $signed(ia);
    int sb = $signed(ib);
    int r, sr;
    if (is) begin
      r      = ua - ub;
      sr     = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      r      = ua + ub + int'(ic);
      sr     = sa + sb + int'(ic);
      e.cout = (r > 255);
    end
    e.sum = r[7:0];
    e.ovf = (sr > 127) || (sr < -128);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) check("hold_outputs", {out_valid, sum, cout, ovf}, hold_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("queue_nonempty_at_output", exp_q.size(), 1);
        end else begin
          e_mon = exp_q.pop_front();
          check("sb_sum", sum, e_mon.sum);
          check("sb_cout", cout, e_mon.cout);
          check("sb_ovf", ovf, e_mon.ovf);
          n_pops++;
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_valid, sum, cout, ovf};
      if (in_valid && in_ready) exp_q.push_back(model8(a, b, cin, sub));
    end
  end

  task automatic send8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       input logic is, input logic [7:0] es, input logic ec, input logic eo,
                       input string tag);
    int lat;
    a        = ia;
    b        = ib;
    cin      = ic;
    sub      = is;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    tick();
    sub = 1'b0;
  endtask

  task automatic send32(input logic [31:0] ia, input logic [31:0] ib, input logic ic,
                        input string tag);
    logic [32:0] r;
    longint      sr;
    int          lat;
    r          = {1'b0, ia} + {1'b0, ib} + 33'(ic);
    sr         = longint'($signed(ia)) + longint'($signed(ib)) + longint'(ic);
    a32        = ia;
    b32        = ib;
    cin32      = ic;
    in_valid32 = 1'b1;
    tick();
    in_valid32 = 1'b0;
    lat        = 1;
    while (!out_valid32 && lat < 30) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, sum32, r[31:0]);
    check({tag, "_cout"}, cout32, r[32]);
    check({tag, "_ovf"}, ovf32, (sr > 64'sd2147483647) || (sr < -64'sd2147483648));
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    int          base;
    logic [7:0]  sa0, sb0;
    logic        sc0;
    exp8_t       e0;

    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    a           = '0;
    b           = '0;
    cin         = 1'b0;
    sub         = 1'b0;
    in_valid32  = 1'b0;
    out_ready32 = 1'b1;
    a32         = '0;
    b32         = '0;
    cin32       = 1'b0;
    sub32       = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_valid32", out_valid32, 0);
    check("rst_sum32", sum32, 0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    send8(8'h00, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, "add_0_1");
    send8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_1");
    send8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_1");
    send8(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, "add_cin_ovf");
`ifdef PIPE_ADDER_SUB_EN
    send8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_5_7");
    send8(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_1");
`endif

    // Back-to-back stream: one result per cycle once the pipe is full.
    base = n_pops;
    cin  = 1'b0;
    for (int i = 0; i < 255; i++) begin
      if (i < 128) begin
        a = i[7:0];
        b = 8'h01;
      end else begin
        a = 8'h80;
        b = 8'(8'h81 + i - 128);
      end
      in_valid = 1'b1;
      tick();
      if (i >= 1) check("stream_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    repeat (4) tick();
    check("stream_count", n_pops - base, 255);

    // Stall with a full pipeline; operands changing while not ready must be ignored.
    base     = n_pops;
    sa0      = 8'($urandom);
    sb0      = 8'($urandom);
    sc0      = 1'($urandom);
    e0       = model8(sa0, sb0, sc0, 1'b0);
    a        = sa0;
    b        = sb0;
    cin      = sc0;
    in_valid = 1'b1;
    tick();
    a   = 8'($urandom);
    b   = 8'($urandom);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      tick();
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_sum", sum, e0.sum);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (4) tick();
    check("stall_count", n_pops - base, 2);

    // Reset with two items in flight: neither may ever emerge.
    base     = n_pops;
    a        = 8'hAA;
    b        = 8'h11;
    cin      = 1'b0;
    in_valid = 1'b1;
    tick();
    a = 8'h55;
    b = 8'h22;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    check("midrst_ovf", ovf, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_emit", out_valid, 0);
    end
    check("midrst_count", n_pops - base, 0);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      a         = 8'($urandom);
      b         = 8'($urandom);
      cin       = 1'($urandom);
`ifdef PIPE_ADDER_SUB_EN
      sub       = 1'($urandom);
`endif
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sub       = 1'b0;
    repeat (5) tick();
    check("drain_empty", exp_q.size(), 0);

    // Wide instance: carry ripples across all four stages.
    send32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "w32_ripple");
    send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "w32_ovf");
    send32(32'h8000_0000, 32'h8000_0000, 1'b0, "w32_neg_ovf");
    for (int i = 0; i < 8; i++) begin
      send32($urandom, $urandom, 1'($urandom), "w32_rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
